tank_move_arbiter: RTL and testbench
====================================

// Module: tank_move_arbiter
// PURPOSE
//  Shared move scheduler for both tanks on the 20x15 tile map. On each frame tick it
//  serially looks up both requested target tiles in the single-port map RAM, then
//  resolves walls, bounds and tank-vs-tank conflicts with round-robin priority.
//  It owns both tank positions and feeds them to the renderer and the bullet logic.
// PARAMETERS
//  MAP_W    20   tiles per row; map_addr = y*MAP_W + x
//  MAP_H    15   tile rows
//  T0_X/Y   1/13 tank 0 (player 1, WASD) reset tile
//  T1_X/Y   18/1 tank 1 (player 2, arrows) reset tile
// PORTS
//  frame_clk   in   1   single clock
//  Reset       in   1   synchronous, active-high
//  move_tick   in   1   one-cycle pulse: start a move round
//  dir0, dir1  in   3   0 none, 1 up (y-1), 2 down (y+1), 3 left (x-1), 4 right (x+1); 5-7 = none
//  map_rd      out  1   map RAM read strobe
//  map_addr    out  9   map RAM address (registered)
//  map_data    in   8   map RAM data, valid the cycle after map_rd; nonzero = wall
//  tank0_x/y   out  5/4 tank 0 tile position
//  tank1_x/y   out  5/4 tank 1 tile position
//  moved       out  2   bit i = tank i moved in the last round (held until next done)
//  busy        out  1   round in progress
//  done        out  1   one-cycle pulse: round complete, positions updated
// BEHAVIOUR
//  Reset: positions = T0/T1 params; moved=0, busy=0, done=0, map_rd=0, map_addr=0,
//   priority=tank 0, FSM=IDLE. Reset mid-round aborts the round; no position change.
//  FSM: IDLE -> RD0 -> RD1 -> RESOLVE -> IDLE.
//   IDLE: on move_tick, latch dir0/dir1, compute targets tgt0/tgt1 -> RD0.
//   RD0: map_rd=1, map_addr=tgt0. RD1: capture wall0, map_rd=1, map_addr=tgt1.
//   RESOLVE: capture wall1, apply rules, register positions/moved, done=1 -> IDLE.
//  Latency: tick sampled at cycle T -> done and new positions visible at T+4.
//  move_tick while busy is ignored (not queued). busy=1 in RD0, RD1, RESOLVE.
//  Target: dir none -> target = own tile, tank stays, not counted as blocked.
//  Bounds: x-1 at x=0, x+1 at x=MAP_W-1, y-1 at y=0, y+1 at y=MAP_H-1 -> blocked;
//   map_rd still low for that slot, map_addr=0; no wrap-around.
//  Rules (tank i may move only if all hold):
//   a) target in bounds and map_data==0;
//   b) target != other tank's CURRENT tile (blocks swaps and following);
//   c) if both valid and tgt0==tgt1: priority tank moves, other blocked,
//      priority then toggles. Priority changes only on a c) conflict.
//  Arithmetic: address = y*MAP_W + x in 9 bits (max 299); no out-of-range address issued.
// CONFIGURATION
//  TANK_ARB_STATS_EN defined: adds outputs blocked_cnt (16 b) and conflict_cnt (16 b).
//   blocked_cnt += number of tanks blocked by a)/b) per round (0..2).
//   conflict_cnt += 1 per c) conflict. Both saturate at 16'hFFFF; cleared by Reset.
//  Undefined: the counters and their ports are absent; other behaviour is identical.
// TESTING
//  1 Reset, tick, dir0=4, dir1=3, map all 0 -> T+4: done, tank0=(2,13), tank1=(17,1), moved=2'b11.
//  2 tank0 at (0,5), dir0=3 -> no map_rd in RD0, tank0 stays (0,5), moved[0]=0.
//  3 map[13*20+2]=1, tank0 (1,13), dir0=4 -> map_addr=262 in RD0, tank0 stays.
//  4 tank0 (5,5), tank1 (7,5), dir0=4, dir1=3, twice -> round 1: tank0 to (6,5), tank1 stays;
//    round 2: tank1 (prio now) refused since (6,5) occupied; conflict counted only in round 1.
//  5 tank0 (5,5), tank1 (6,5), dir0=4, dir1=3 -> swap refused, both stay, moved=0.
//  6 tick, Reset at T+2, tick while busy -> positions = reset tiles, no done; busy tick ignored.

Source files
------------

// File: rtl/tank_move_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tank_move_arbiter_if
// Purpose  : Bundles the move-round handshake, the map RAM read port and the
//            tank position outputs of the shared tank move scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface tank_move_arbiter_if;
  logic       move_tick;
  logic [2:0] dir0;
  logic [2:0] dir1;
  logic       map_rd;
  logic [8:0] map_addr;
  logic [7:0] map_data;
  logic [4:0] tank0_x;
  logic [3:0] tank0_y;
  logic [4:0] tank1_x;
  logic [3:0] tank1_y;
  logic [1:0] moved;
  logic       busy;
  logic       done;

  // Scheduler side: consumes requests and RAM data, owns positions.
  modport slave (
    input  move_tick, dir0, dir1, map_data,
    output map_rd, map_addr, tank0_x, tank0_y, tank1_x, tank1_y,
           moved, busy, done
  );

  // Game-logic / RAM side: issues requests and answers map reads.
  modport master (
    output move_tick, dir0, dir1, map_data,
    input  map_rd, map_addr, tank0_x, tank0_y, tank1_x, tank1_y,
           moved, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/tank_move_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tank_move_arbiter
// Purpose  : Shared move scheduler for both tanks on the tile map. Per round
//            it reads both target tiles from the single-port map RAM, then
//            resolves walls, map bounds and tank-vs-tank conflicts with a
//            round-robin priority that flips only on a same-tile conflict.
// Options  : TANK_ARB_STATS_EN adds saturating blocked/conflict counters.
// Revision : 1.0  initial release
// ============================================================================
module tank_move_arbiter #(
  parameter int MAP_W = 20,
  parameter int MAP_H = 15,
  parameter int T0_X  = 1,
  parameter int T0_Y  = 13,
  parameter int T1_X  = 18,
  parameter int T1_Y  = 1
) (
  input  logic               frame_clk,
  input  logic               Reset,
  tank_move_arbiter_if.slave bus
`ifdef TANK_ARB_STATS_EN
  ,
  output logic [15:0]        blocked_cnt,
  output logic [15:0]        conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD0     = 2'd1,
    S_RD1     = 2'd2,
    S_RESOLVE = 2'd3
  } state_t;

  // Resolved request of one tank: mv = a real direction was given,
  // inb = the neighbouring tile exists on the map.
  typedef struct packed {
    logic       mv;
    logic       inb;
    logic [4:0] x;
    logic [3:0] y;
  } tgt_t;

  localparam logic [4:0] c_t0_x   = 5'(T0_X);
  localparam logic [3:0] c_t0_y   = 4'(T0_Y);
  localparam logic [4:0] c_t1_x   = 5'(T1_X);
  localparam logic [3:0] c_t1_y   = 4'(T1_Y);
  localparam logic [4:0] c_last_x = 5'(MAP_W - 1);
  localparam logic [3:0] c_last_y = 4'(MAP_H - 1);
  localparam logic [8:0] c_map_w  = 9'(MAP_W);

  // Neighbour tile for a direction code; an off-map step keeps the own tile
  // and clears inb so that no RAM read is issued for it.
  function automatic tgt_t f_target(input logic [2:0] dir,
                                    input logic [4:0] x,
                                    input logic [3:0] y);
    tgt_t t;
    t.mv  = 1'b1;
    t.inb = 1'b1;
    t.x   = x;
    t.y   = y;
    case (dir)
      3'd1: if (y == 4'd0)     t.inb = 1'b0; else t.y = y - 4'd1;
      3'd2: if (y == c_last_y) t.inb = 1'b0; else t.y = y + 4'd1;
      3'd3: if (x == 5'd0)     t.inb = 1'b0; else t.x = x - 5'd1;
      3'd4: if (x == c_last_x) t.inb = 1'b0; else t.x = x + 5'd1;
      default: begin
        t.mv  = 1'b0;
        t.inb = 1'b0;
      end
    endcase
    return t;
  endfunction

  // Linear map address; zero whenever the slot performs no read.
  function automatic logic [8:0] f_addr(input tgt_t t);
    logic [8:0] a;
    a = 9'd0;
    if (t.mv && t.inb) a = (9'(t.y) * c_map_w) + 9'(t.x);
    return a;
  endfunction

  state_t     state_q, state_d;
  tgt_t       tgt0_q, tgt0_d;
  tgt_t       tgt1_q, tgt1_d;
  logic       wall0_q, wall0_d;
  logic       prio_q, prio_d;        // 0: tank 0 wins a same-tile conflict
  logic [4:0] tank0_x_q, tank0_x_d;
  logic [3:0] tank0_y_q, tank0_y_d;
  logic [4:0] tank1_x_q, tank1_x_d;
  logic [3:0] tank1_y_q, tank1_y_d;
  logic [1:0] moved_q, moved_d;
  logic       done_q, done_d;
  logic       map_rd_q, map_rd_d;
  logic [8:0] map_addr_q, map_addr_d;

  logic       wall1;
  logic       occ0, occ1;
  logic       ok_ab0, ok_ab1;
  logic       conflict;
  logic       win0, win1;

  // Move legality for the RESOLVE cycle; slot 1's wall bit is live RAM data.
  always_comb begin
    wall1    = |bus.map_data;
    occ0     = (tgt0_q.x == tank1_x_q) && (tgt0_q.y == tank1_y_q);
    occ1     = (tgt1_q.x == tank0_x_q) && (tgt1_q.y == tank0_y_q);
    ok_ab0   = tgt0_q.mv & tgt0_q.inb & ~wall0_q & ~occ0;
    ok_ab1   = tgt1_q.mv & tgt1_q.inb & ~wall1   & ~occ1;
    conflict = ok_ab0 & ok_ab1 &
               (tgt0_q.x == tgt1_q.x) & (tgt0_q.y == tgt1_q.y);
    win0     = ok_ab0 & ~(conflict &  prio_q);
    win1     = ok_ab1 & ~(conflict & ~prio_q);
  end

  // Round sequencer: next state, RAM read strobes and position updates.
  always_comb begin
    state_d    = state_q;
    tgt0_d     = tgt0_q;
    tgt1_d     = tgt1_q;
    wall0_d    = wall0_q;
    prio_d     = prio_q;
    tank0_x_d  = tank0_x_q;
    tank0_y_d  = tank0_y_q;
    tank1_x_d  = tank1_x_q;
    tank1_y_d  = tank1_y_q;
    moved_d    = moved_q;
    done_d     = 1'b0;
    map_rd_d   = 1'b0;
    map_addr_d = 9'd0;
    case (state_q)
      S_IDLE: begin
        if (bus.move_tick) begin
          tgt0_d     = f_target(bus.dir0, tank0_x_q, tank0_y_q);
          tgt1_d     = f_target(bus.dir1, tank1_x_q, tank1_y_q);
          map_rd_d   = tgt0_d.mv & tgt0_d.inb;
          map_addr_d = f_addr(tgt0_d);
          state_d    = S_RD0;
        end
      end
      S_RD0: begin
        map_rd_d   = tgt1_q.mv & tgt1_q.inb;
        map_addr_d = f_addr(tgt1_q);
        state_d    = S_RD1;
      end
      S_RD1: begin
        wall0_d = |bus.map_data;
        state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (win0) begin
          tank0_x_d = tgt0_q.x;
          tank0_y_d = tgt0_q.y;
        end
        if (win1) begin
          tank1_x_d = tgt1_q.x;
          tank1_y_d = tgt1_q.y;
        end
        if (conflict) prio_d = ~prio_q;
        moved_d = {win1, win0};
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any round in flight.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      tgt0_q     <= '0;
      tgt1_q     <= '0;
      wall0_q    <= 1'b0;
      prio_q     <= 1'b0;
      tank0_x_q  <= c_t0_x;
      tank0_y_q  <= c_t0_y;
      tank1_x_q  <= c_t1_x;
      tank1_y_q  <= c_t1_y;
      moved_q    <= 2'b00;
      done_q     <= 1'b0;
      map_rd_q   <= 1'b0;
      map_addr_q <= 9'd0;
    end else begin
      state_q    <= state_d;
      tgt0_q     <= tgt0_d;
      tgt1_q     <= tgt1_d;
      wall0_q    <= wall0_d;
      prio_q     <= prio_d;
      tank0_x_q  <= tank0_x_d;
      tank0_y_q  <= tank0_y_d;
      tank1_x_q  <= tank1_x_d;
      tank1_y_q  <= tank1_y_d;
      moved_q    <= moved_d;
      done_q     <= done_d;
      map_rd_q   <= map_rd_d;
      map_addr_q <= map_addr_d;
    end
  end

  assign bus.map_rd   = map_rd_q;
  assign bus.map_addr = map_addr_q;
  assign bus.tank0_x  = tank0_x_q;
  assign bus.tank0_y  = tank0_y_q;
  assign bus.tank1_x  = tank1_x_q;
  assign bus.tank1_y  = tank1_y_q;
  assign bus.moved    = moved_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;

`ifdef TANK_ARB_STATS_EN
  logic [1:0]  blk_inc;
  logic [16:0] blk_sum;
  logic [16:0] cfl_sum;
  logic [15:0] blocked_cnt_q, blocked_cnt_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Saturating statistics: a/b-rule refusals and same-tile conflicts.
  always_comb begin
    blk_inc        = 2'(tgt0_q.mv & ~ok_ab0) + 2'(tgt1_q.mv & ~ok_ab1);
    blk_sum        = {1'b0, blocked_cnt_q} + 17'(blk_inc);
    cfl_sum        = {1'b0, conflict_cnt_q} + 17'(conflict);
    blocked_cnt_d  = blocked_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (state_q == S_RESOLVE) begin
      blocked_cnt_d  = blk_sum[16] ? 16'hFFFF : blk_sum[15:0];
      conflict_cnt_d = cfl_sum[16] ? 16'hFFFF : cfl_sum[15:0];
    end
  end

  // Counter registers, cleared with the rest of the scheduler.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      blocked_cnt_q  <= 16'd0;
      conflict_cnt_q <= 16'd0;
    end else begin
      blocked_cnt_q  <= blocked_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign blocked_cnt  = blocked_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`else
  // Statistics hardware not built; scheduling behaviour is unchanged.
`endif

endmodule
`default_nettype wire

// File: tb/tb_tank_move_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tank_move_arbiter
// Purpose  : Self-checking bench for tank_move_arbiter with a behavioural
//            map RAM, a reference move model and an expected-result queue.
// Options  : TANK_ARB_STATS_EN also checks the statistics counters.
// Revision : 1.0  initial release
// ============================================================================
module tb_tank_move_arbiter;

  typedef struct {
    logic [4:0]  x0;
    logic [3:0]  y0;
    logic [4:0]  x1;
    logic [3:0]  y1;
    logic [1:0]  moved;
    logic [15:0] blk;
    logic [15:0] cfl;
  } exp_t;

  logic clk;
  logic rst;
  tank_move_arbiter_if bus ();
`ifdef TANK_ARB_STATS_EN
  logic [15:0] blocked_cnt;
  logic [15:0] conflict_cnt;
`endif

  tank_move_arbiter dut (
    .frame_clk    (clk),
    .Reset        (rst),
    .bus          (bus)
`ifdef TANK_ARB_STATS_EN
    ,
    .blocked_cnt  (blocked_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Map RAM: one-cycle read latency.
  logic [7:0] mem [300];
  always @(posedge clk) begin
    if (rst) bus.map_data <= 8'd0;
    else if (bus.map_rd) bus.map_data <= mem[bus.map_addr];
  end

  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  int   mx0, my0, mx1, my1, mblk, mcfl;
  bit   mprio;
  bit   e_mv [2];
  bit   e_rd [2];
  int   e_addr [2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx0 = 1;  my0 = 13;
    mx1 = 18; my1 = 1;
    mprio = 1'b0;
    mblk = 0; mcfl = 0;
    exp_q.delete();
  endtask

  // Reference move rules for one round; updates model state.
  task automatic model_round(input logic [2:0] d0, input logic [2:0] d1, output exp_t e);
    int px [2], py [2], tx [2], ty [2];
    bit ok [2];
    logic [2:0] d [2];
    px[0] = mx0; py[0] = my0; px[1] = mx1; py[1] = my1;
    d[0] = d0; d[1] = d1;
    for (int i = 0; i < 2; i++) begin
      tx[i] = px[i]; ty[i] = py[i];
      e_mv[i] = 1'b1; ok[i] = 1'b1;
      case (d[i])
        3'd1: if (py[i] == 0)  ok[i] = 1'b0; else ty[i] = py[i] - 1;
        3'd2: if (py[i] == 14) ok[i] = 1'b0; else ty[i] = py[i] + 1;
        3'd3: if (px[i] == 0)  ok[i] = 1'b0; else tx[i] = px[i] - 1;
        3'd4: if (px[i] == 19) ok[i] = 1'b0; else tx[i] = px[i] + 1;
        default: begin e_mv[i] = 1'b0; ok[i] = 1'b0; end
      endcase
      e_rd[i]   = e_mv[i] && ok[i];
      e_addr[i] = e_rd[i] ? (ty[i] * 20 + tx[i]) : 0;
      if (e_rd[i] && mem[e_addr[i]] != 8'd0) ok[i] = 1'b0;
      if (ok[i] && tx[i] == px[1-i] && ty[i] == py[1-i]) ok[i] = 1'b0;
      if (e_mv[i] && !ok[i]) mblk++;
    end
    if (ok[0] && ok[1] && tx[0] == tx[1] && ty[0] == ty[1]) begin
      mcfl++;
      if (mprio) ok[0] = 1'b0; else ok[1] = 1'b0;
      mprio = !mprio;
    end
    if (ok[0]) begin mx0 = tx[0]; my0 = ty[0]; end
    if (ok[1]) begin mx1 = tx[1]; my1 = ty[1]; end
    e.x0 = 5'(mx0); e.y0 = 4'(my0);
    e.x1 = 5'(mx1); e.y1 = 4'(my1);
    e.moved = {ok[1], ok[0]};
    e.blk = 16'(mblk);
    e.cfl = 16'(mcfl);
  endtask

  task automatic compare_done();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("pos0", 32'({bus.tank0_x, bus.tank0_y}), 32'({e.x0, e.y0}));
    chk("pos1", 32'({bus.tank1_x, bus.tank1_y}), 32'({e.x1, e.y1}));
    chk("moved", 32'(bus.moved), 32'(e.moved));
`ifdef TANK_ARB_STATS_EN
    chk("blocked_cnt", 32'(blocked_cnt), 32'(e.blk));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(e.cfl));
`endif
  endtask

  // One full round from IDLE: drive tick, check both read slots, wait done.
  task automatic round(input logic [2:0] d0, input logic [2:0] d1);
    exp_t e;
    int   lat;
    bit   seen;
    model_round(d0, d1, e);
    exp_q.push_back(e);
    bus.move_tick = 1'b1; bus.dir0 = d0; bus.dir1 = d1;
    @(negedge clk);
    bus.move_tick = 1'b0; bus.dir0 = 3'd0; bus.dir1 = 3'd0;
    chk("busy_rd0", 32'(bus.busy), 32'd1);
    if (e_mv[0]) begin
      chk("map_rd0", 32'(bus.map_rd), 32'(e_rd[0]));
      chk("map_addr0", 32'(bus.map_addr), 32'(e_addr[0]));
    end
    @(negedge clk);
    if (e_mv[1]) begin
      chk("map_rd1", 32'(bus.map_rd), 32'(e_rd[1]));
      chk("map_addr1", 32'(bus.map_addr), 32'(e_addr[1]));
    end
    lat = 2; seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      if (bus.done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("latency", 32'(lat), 32'd4);
      compare_done();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int ndone;
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    bus.move_tick = 1'b0; bus.dir0 = 3'd0; bus.dir1 = 3'd0;
    for (int i = 0; i < 300; i++) mem[i] = 8'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_pos0", 32'({bus.tank0_x, bus.tank0_y}), 32'({5'd1, 4'd13}));
    chk("rst_pos1", 32'({bus.tank1_x, bus.tank1_y}), 32'({5'd18, 4'd1}));
    chk("rst_moved", 32'(bus.moved), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_map_rd", 32'(bus.map_rd), 32'd0);
    chk("rst_map_addr", 32'(bus.map_addr), 32'd0);

    // Basic move, empty map
    round(3'd4, 3'd3);
    chk("t1_pos0", 32'({bus.tank0_x, bus.tank0_y}), 32'({5'd2, 4'd13}));
    chk("t1_pos1", 32'({bus.tank1_x, bus.tank1_y}), 32'({5'd17, 4'd1}));
    chk("t1_moved", 32'(bus.moved), 32'd3);

    // Map edges on every side
    round(3'd3, 3'd1);
    round(3'd3, 3'd1);
    round(3'd3, 3'd4);
    round(3'd2, 3'd4);
    round(3'd2, 3'd4);
    chk("edge_pos0", 32'({bus.tank0_x, bus.tank0_y}), 32'({5'd0, 4'd14}));
    chk("edge_pos1", 32'({bus.tank1_x, bus.tank1_y}), 32'({5'd19, 4'd0}));
    chk("edge_moved", 32'(bus.moved), 32'd0);

    // Wall in front of tank 0
    do_reset();
    mem[262] = 8'd1;
    round(3'd4, 3'd0);
    chk("wall_pos0", 32'({bus.tank0_x, bus.tank0_y}), 32'({5'd1, 4'd13}));
    mem[262] = 8'd0;

    // Same-tile conflict, swap refusal, priority rotation
    do_reset();
    repeat (12) round(3'd1, 3'd3);
    repeat (3) round(3'd0, 3'd3);
    round(3'd4, 3'd3);
    chk("cfl1_pos0", 32'({bus.tank0_x, bus.tank0_y}), 32'({5'd2, 4'd1}));
    chk("cfl1_moved", 32'(bus.moved), 32'd1);
    round(3'd4, 3'd3);
    chk("swap_moved", 32'(bus.moved), 32'd0);
    round(3'd3, 3'd0);
    round(3'd4, 3'd3);
    chk("cfl2_pos1", 32'({bus.tank1_x, bus.tank1_y}), 32'({5'd2, 4'd1}));
    chk("cfl2_moved", 32'(bus.moved), 32'd2);

    // Tick while busy is dropped, not queued
    begin
      exp_t e;
      model_round(3'd2, 3'd0, e);
      exp_q.push_back(e);
      bus.move_tick = 1'b1; bus.dir0 = 3'd2; bus.dir1 = 3'd0;
      ndone = 0;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (k == 1) begin
          bus.move_tick = 1'b1; bus.dir0 = 3'd3; bus.dir1 = 3'd2;
        end else begin
          bus.move_tick = 1'b0; bus.dir0 = 3'd0; bus.dir1 = 3'd0;
        end
        if (bus.done) begin
          ndone++;
          compare_done();
        end
      end
      chk("busy_tick_dones", 32'(ndone), 32'd1);
    end

    // Reset in the middle of a round
    bus.move_tick = 1'b1; bus.dir0 = 3'd1; bus.dir1 = 3'd2;
    @(negedge clk);
    bus.move_tick = 1'b0; bus.dir0 = 3'd0; bus.dir1 = 3'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_dones", 32'(ndone), 32'd0);
    chk("abort_pos0", 32'({bus.tank0_x, bus.tank0_y}), 32'({5'd1, 4'd13}));
    chk("abort_pos1", 32'({bus.tank1_x, bus.tank1_y}), 32'({5'd18, 4'd1}));
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_moved", 32'(bus.moved), 32'd0);

    // Random walls and directions
    for (int i = 0; i < 40; i++) mem[$urandom_range(0, 299)] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 60; i++) round(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
